// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data width, parity and stop bits.
// Each bit is a 3-sample majority vote; words go out through a registered valid/ready port.
module uart_rx_framed #(
  parameter int CLK_SPEED = 5_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BAUD_TICK = CLK_SPEED / BAUD_RATE;
  localparam int MID       = BAUD_TICK / 2;
  localparam int CNT_W     = $clog2(BAUD_TICK);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_TICK - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PAR       = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic                 sync_meta;
  logic                 rxs;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 s0;
  logic                 s1;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 ferr;

  logic tick_end;
  logic decide;
  logic bit_val;
  logic par_exp;
  logic frame_done;
  logic ferr_final;

  always_comb begin
    tick_end   = (cnt == CNT_LAST);
    decide     = (cnt == CNT_DEC);
    // Third sample is the live synchronised value at the decision count.
    bit_val    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    par_exp    = (^shift) ^ (PARITY == 1);
    frame_done = (state == STOP) && decide && (bit_idx == LAST_STOP);
    ferr_final = ferr | ~bit_val;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta  <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shift      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_meta <= rx;
      rxs       <= sync_meta;

      if (state == IDLE || tick_end) cnt <= '0;
      else                           cnt <= cnt + 1'b1;

      if (cnt == CNT_S0) s0 <= rxs;
      if (cnt == CNT_S1) s1 <= rxs;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            bit_idx <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
          end
        end
        START: begin
          if (decide && bit_val) begin
            state <= IDLE;
          end else if (tick_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (decide) shift <= {bit_val, shift[DATA_BITS-1:1]};
          if (tick_end) begin
            if (bit_idx == LAST_DATA) begin
              state   <= (PARITY != 0) ? PAR : STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PAR: begin
          if (decide) perr <= (bit_val != par_exp);
          if (tick_end) begin
            state   <= STOP;
            bit_idx <= '0;
          end
        end
        STOP: begin
          if (decide) begin
            ferr <= ferr_final;
            // The frame ends at the last stop decision so a following start bit can resync early.
            if (bit_idx == LAST_STOP) state <= bit_val ? IDLE : WAIT_HIGH;
          end
          if (tick_end) bit_idx <= bit_idx + 1'b1;
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (frame_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          parity_err <= perr;
          frame_err  <= ferr_final;
          overrun    <= 1'b0;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: an 8N1 instance and a 7E1 instance, bit-accurate line driver,
// and a queue of expected frames checked whenever the consumer takes a word.
module tb_uart_rx_framed;

  localparam int BT  = 16;
  localparam int MID = 8;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] data_out_a;
  logic [6:0] data_out_b;
  logic       data_valid_a, data_valid_b;
  logic       data_ready_a, data_ready_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic       overrun_a, overrun_b;
  logic       busy_a, busy_b;

  int   checks;
  int   errors;
  int   cyc;
  int   start_cyc;
  int   frames_a;
  int   frames_b;
  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx_framed #(
    .CLK_SPEED(1_600_000), .BAUD_RATE(100_000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .rx(rx_a),
    .data_out(data_out_a), .data_valid(data_valid_a), .data_ready(data_ready_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a),
    .busy(busy_a)
  );

  uart_rx_framed #(
    .CLK_SPEED(1_600_000), .BAUD_RATE(100_000),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .rx(rx_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .data_ready(data_ready_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b),
    .busy(busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Consumer-side scoreboards: every accepted word must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && data_valid_a && data_ready_a) begin
      exp_t e;
      frames_a++;
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_a: got data=%h perr=%b ferr=%b ovr=%b, none expected",
                 data_out_a, parity_err_a, frame_err_a, overrun_a);
      end else begin
        e = q_a.pop_front();
        if ({data_out_a, parity_err_a, frame_err_a, overrun_a} !== {e.data[7:0], e.perr, e.ferr, e.ovr}) begin
          errors++;
          $display("FAIL frame_a: got data=%h perr=%b ferr=%b ovr=%b, expected data=%h perr=%b ferr=%b ovr=%b",
                   data_out_a, parity_err_a, frame_err_a, overrun_a, e.data[7:0], e.perr, e.ferr, e.ovr);
        end
      end
      $display("frame_a: data=%h perr=%b ferr=%b ovr=%b", data_out_a, parity_err_a, frame_err_a, overrun_a);
    end
    if (reset_n && data_valid_b && data_ready_b) begin
      exp_t e;
      frames_b++;
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_b: got data=%h perr=%b ferr=%b, none expected",
                 data_out_b, parity_err_b, frame_err_b);
      end else begin
        e = q_b.pop_front();
        if ({data_out_b, parity_err_b, frame_err_b, overrun_b} !== {e.data[6:0], e.perr, e.ferr, e.ovr}) begin
          errors++;
          $display("FAIL frame_b: got data=%h perr=%b ferr=%b ovr=%b, expected data=%h perr=%b ferr=%b ovr=%b",
                   data_out_b, parity_err_b, frame_err_b, overrun_b, e.data[6:0], e.perr, e.ferr, e.ovr);
        end
      end
      $display("frame_b: data=%h perr=%b ferr=%b ovr=%b", data_out_b, parity_err_b, frame_err_b, overrun_b);
    end
  end

  task automatic drive_bit(input bit sel, input logic v, input bit glitch);
    for (int c = 0; c < BT; c++) begin
      logic lv;
      lv = (glitch && c == 9) ? ~v : v;
      if (sel) rx_b = lv;
      else     rx_a = lv;
      @(posedge clock); #1;
    end
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit, input logic stop_val,
                            input int glitch_bit);
    start_cyc = cyc;
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], glitch_bit == i);
    if (has_par) drive_bit(sel, par_bit, 1'b0);
    drive_bit(sel, stop_val, 1'b0);
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (q_a.size() + q_b.size() !== 0) begin
      errors++;
      $display("FAIL %s_pending: %0d frames still expected, required 0", name, q_a.size() + q_b.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({data_out_a, data_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, required all 0",
               data_out_a, data_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a);
    end
    checks++;
    if ({data_out_b, data_valid_b, busy_b} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: got data=%h v=%b busy=%b, required 0", data_out_b, data_valid_b, busy_b);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n;
    q_a.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    fork
      send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, -1);
      begin
        n = 0;
        @(negedge clock);
        while (!data_valid_a && n < 300) begin
          @(negedge clock);
          n++;
        end
        checks++;
        if (!data_valid_a) begin
          errors++;
          $display("FAIL basic_timeout: data_valid never rose within 300 cycles");
        end else begin
          // Start detect costs 3 cycles, then 9 full bits, then the decision at MID+1 plus one register stage.
          checks++;
          if (cyc - start_cyc !== 3 + BT * 9 + MID + 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required %0d", cyc - start_cyc, 3 + BT * 9 + MID + 2);
          end
          @(negedge clock);
          if (data_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_pulse: data_valid=%b one cycle later, required 0", data_valid_a);
          end
        end
      end
    join
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 0", busy_a);
    end
    check_empty("basic");
    $display("test_basic done");
  endtask

  task automatic test_parity();
    // Even parity over 7'h03 is 0, so a parity bit of 1 is a mismatch.
    q_b.push_back('{data: 9'h003, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    send_frame(1'b1, 9'h003, 7, 1'b1, 1'b1, 1'b1, -1);
    q_b.push_back('{data: 9'h003, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(1'b1, 9'h003, 7, 1'b1, 1'b0, 1'b1, -1);
    q_b.push_back('{data: 9'h055, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(1'b1, 9'h055, 7, 1'b1, 1'b0, 1'b1, -1);
    check_empty("parity");
    $display("test_parity done");
  endtask

  task automatic test_break();
    int f0;
    f0 = frames_a;
    q_a.push_back('{data: 9'h00F, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    send_frame(1'b0, 9'h00F, 8, 1'b0, 1'b0, 1'b0, -1);
    rx_a = 1'b0;
    repeat (40 * BT) @(posedge clock);
    #1;
    checks++;
    if (frames_a - f0 !== 1) begin
      errors++;
      $display("FAIL break_frames: got %0d frames during break, required 1", frames_a - f0);
    end
    rx_a = 1'b1;
    repeat (2 * BT) @(posedge clock);
    #1;
    q_a.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, -1);
    check_empty("break");
    $display("test_break done");
  endtask

  task automatic test_noise();
    int n;
    int f0;
    f0 = frames_a;
    rx_a = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rx_a = 1'b1;
    n = 0;
    while (busy_a && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n < 1 || n > MID + 2) begin
      errors++;
      $display("FAIL noise_busy: busy lasted %0d cycles, required 1..%0d", n, MID + 2);
    end
    repeat (2 * BT) @(posedge clock);
    #1;
    checks++;
    if (frames_a !== f0) begin
      errors++;
      $display("FAIL noise_no_frame: got %0d frames, required 0", frames_a - f0);
    end
    q_a.push_back('{data: 9'h0FF, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(1'b0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 2);
    check_empty("noise");
    $display("test_noise done");
  endtask

  task automatic test_overrun();
    data_ready_a = 1'b0;
    q_a.push_back('{data: 9'h011, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, -1);
    checks++;
    if ({data_valid_a, data_out_a, overrun_a} !== {1'b1, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL overrun_first: got v=%b data=%h ov=%b, required v=1 data=11 ov=0",
               data_valid_a, data_out_a, overrun_a);
    end
    send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, -1);
    checks++;
    if ({data_valid_a, data_out_a, overrun_a} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL overrun_second: got v=%b data=%h ov=%b, required v=1 data=11 ov=1",
               data_valid_a, data_out_a, overrun_a);
    end
    data_ready_a = 1'b1;
    @(posedge clock); #1;
    data_ready_a = 1'b0;
    checks++;
    if ({data_valid_a, overrun_a, data_out_a} !== {1'b0, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL overrun_clear: got v=%b ov=%b data=%h, required v=0 ov=0 data=11",
               data_valid_a, overrun_a, data_out_a);
    end
    data_ready_a = 1'b1;
    check_empty("overrun");
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] junk;
    junk = 8'h77;
    drive_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, junk[i], 1'b0);
    rx_a = junk[4];
    repeat (MID) @(posedge clock);
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: got %b before reset, required 1", busy_a);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({data_out_a, data_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a} !== 13'd0) begin
      errors++;
      $display("FAIL midframe_reset: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, required all 0",
               data_out_a, data_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a);
    end
    rx_a = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2 * BT) @(posedge clock);
    #1;
    q_a.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, -1);
    check_empty("midframe");
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    start_cyc    = 0;
    frames_a     = 0;
    frames_b     = 0;
    reset_n      = 1'b0;
    rx_a         = 1'b1;
    rx_b         = 1'b1;
    data_ready_a = 1'b1;
    data_ready_b = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    repeat (BT) @(posedge clock);
    #1;
    test_basic();
    test_parity();
    test_break();
    test_noise();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Each bit is decided by a 3-sample majority vote, and parity and framing errors are reported. Received words are delivered to the downstream consumer through a registered valid/ready output with overrun detection. It sits between the rx pad and the command/FIFO logic.

Parameters:
CLK_SPEED, 5_000_000, clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2
Derived (localparam): BAUD_TICK = CLK_SPEED/BAUD_RATE (must be >= 8); MID = BAUD_TICK/2; CNT_W = $clog2(BAUD_TICK)

Ports:
clock  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received word, LSB = first bit on the line
data_valid  output  1  data_out and the flags hold an unconsumed frame
data_ready  input  1  consumer accepts the frame when high together with data_valid
parity_err  output  1  parity mismatch for the held frame (always 0 when PARITY=0)
frame_err  output  1  at least one stop bit sampled low for the held frame
overrun  output  1  one or more frames dropped while the held frame was pending
busy  output  1  receiver is not in IDLE

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; all outputs 0; data_out = 0.
  - The synchroniser flops reset to 1.
  - Reset mid-frame abandons the frame; no partial delivery.
- Input synchronisation: rx passes through 2 flops; the FSM sees only the synchronised value (rxs).
- Bit timing:
  - Tick counter runs 0..BAUD_TICK-1, then returns to 0 and advances the bit index.
  - Samples are taken at counts MID-1, MID and MID+1.
  - Bit value = majority of the 3 samples, decided at count MID+1.
- FSM states:
  - IDLE: when rxs == 0, counter := 0 and go to START.
  - START: at decision, a majority of 1 is a false start → IDLE with no output. Otherwise continue to the end of the bit, then go to DATA.
  - DATA: DATA_BITS bits, shifted in LSB first. Go to PARITY if PARITY != 0, else STOP.
  - PARITY: expected parity = XOR of the data bits (odd mode: inverted). Mismatch sets an internal perr.
  - STOP: STOP_BITS bits; any low majority sets an internal ferr.
    - At the decision point of the last stop bit, the frame is complete.
    - Go to IDLE if the last stop bit was high, else WAIT_HIGH.
    - No wait for the end of the stop bit, which allows early resync.
  - WAIT_HIGH: stay until rxs == 1, then go to IDLE. This prevents a held-low line or break from generating repeated frames.
- busy = (state != IDLE).
- Delivery (cycle after frame completion):
  - If data_valid == 0, or (data_valid && data_ready) in the completion cycle: load data_out, parity_err := perr, frame_err := ferr, overrun := 0, data_valid := 1.
  - If data_valid && !data_ready: the new frame is discarded; overrun := 1 and the held data and flags are unchanged.
- Handshake:
  - data_valid && data_ready with no completion that cycle: data_valid, parity_err, frame_err and overrun all clear next cycle.
  - data_out holds its last value.
- Frames with parity_err or frame_err are still delivered; the consumer decides what to do with them.
- Latency: data_valid rises exactly 1 cycle after the MID+1 count of the last stop bit.

Test Plan (CLK_SPEED=1_600_000, BAUD_RATE=100_000 → BAUD_TICK=16, MID=8):
1. 8N1, data_ready=1, send 0xA5 → data_valid high for 1 cycle, data_out=0xA5, parity_err=frame_err=overrun=0, busy returns 0.
2. PARITY=2, DATA_BITS=7:
   - send 0x03 with parity bit 1 → data_out=0x03, parity_err=1.
   - resend with parity bit 0 → parity_err=0.
3. Stop bit driven 0, then rx held low for 40 bit times → exactly one frame with frame_err=1 and no further frames. Release rx high, then send 0x5A → data_out=0x5A, frame_err=0.
4. Noise:
   - rx low for 3 cycles only → no frame, busy back to 0 within MID+2 cycles.
   - single-cycle inversion at count MID of data bit 2 of 0xFF → data_out=0xFF (majority).
5. data_ready=0, send 0x11 then 0x22 → data_out=0x11, overrun=1 after the second frame. Pulse data_ready → data_valid=0 and overrun=0 next cycle.
6. reset_n pulsed low during data bit 4 → outputs 0 immediately. A following frame 0x3C is received correctly.
